esp_dma64_responder: RTL and testbench

Memory-side responder for the 64-bit ESP accelerator DMA interface. It accepts read and write control requests from an accelerator wrapper, serves read bursts from an internal word-addressed SRAM model, and absorbs write bursts into it. It is used in the accelerator-level testbench and in standalone FPGA bring-up in place of the SoC DMA engine, one instance per accelerator.

---
 rtl/esp_dma64_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_esp_dma64_responder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esp_dma64_responder.sv
// Memory-side responder for the 64-bit ESP DMA interface: one read or write burst at a time against a word SRAM.
// Define DMA64_RSP_BACKDOOR_EN to add a backdoor preload/readback port (bd_*); absent by default.
module esp_dma64_responder #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_read_ctrl_valid,
  output logic        dma_read_ctrl_ready,
  input  logic [31:0] dma_read_ctrl_data_index,
  input  logic [31:0] dma_read_ctrl_data_length,
  input  logic [2:0]  dma_read_ctrl_data_size,
  output logic        dma_read_chnl_valid,
  input  logic        dma_read_chnl_ready,
  output logic [63:0] dma_read_chnl_data,
  input  logic        dma_write_ctrl_valid,
  output logic        dma_write_ctrl_ready,
  input  logic [31:0] dma_write_ctrl_data_index,
  input  logic [31:0] dma_write_ctrl_data_length,
  input  logic [2:0]  dma_write_ctrl_data_size,
  input  logic        dma_write_chnl_valid,
  output logic        dma_write_chnl_ready,
  input  logic [63:0] dma_write_chnl_data,
  output logic        busy,
  output logic        oob_err,
  output logic [2:0]  last_size
`ifdef DMA64_RSP_BACKDOOR_EN
  ,
  input  logic              bd_req,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [63:0]       bd_wdata,
  output logic              bd_ack,
  output logic [63:0]       bd_rdata
`endif
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [32:0] MEM_END = 33'(DEPTH);

  // Every channel transfers on a rising edge where valid && ready. Valid never depends on
  // ready; once read valid is high, valid and data hold until the beat is accepted.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              prio_rd;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       beats_left;
  logic [31:0]       issue_left;

  logic              rd_hs;
  logic              wr_hs;
  logic              rd_issue;
  logic              rd_pop;
  logic              wr_beat;
  logic              bd_grant;

  logic [63:0]       fifo_mem [2];
  logic              fifo_wp;
  logic              fifo_rp;
  logic [1:0]        fifo_cnt;

  logic [63:0]       mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [63:0]       mem_wdata;

  logic [32:0]       rd_end;
  logic [32:0]       wr_end;

  assign rd_end = {1'b0, dma_read_ctrl_data_index} + {1'b0, dma_read_ctrl_data_length};
  assign wr_end = {1'b0, dma_write_ctrl_data_index} + {1'b0, dma_write_ctrl_data_length};

  assign busy                = (state != IDLE);
  assign dma_read_chnl_valid = (fifo_cnt != 2'd0);
  assign dma_read_chnl_data  = (fifo_cnt != 2'd0) ? fifo_mem[fifo_rp] : 64'd0;
  assign rd_pop              = dma_read_chnl_valid & dma_read_chnl_ready;
  assign wr_beat             = (state == WR) & dma_write_chnl_valid;

  always_comb begin
    state_nxt            = state;
    dma_read_ctrl_ready  = 1'b0;
    dma_write_ctrl_ready = 1'b0;
    dma_write_chnl_ready = 1'b0;
    rd_issue             = 1'b0;
    rd_hs                = 1'b0;
    wr_hs                = 1'b0;
    case (state)
      IDLE: begin
        dma_read_ctrl_ready  = dma_read_ctrl_valid & (~dma_write_ctrl_valid | prio_rd) & ~bd_grant;
        dma_write_ctrl_ready = dma_write_ctrl_valid & (~dma_read_ctrl_valid | ~prio_rd) & ~bd_grant;
        rd_hs = dma_read_ctrl_valid & dma_read_ctrl_ready;
        wr_hs = dma_write_ctrl_valid & dma_write_ctrl_ready;
        if (rd_hs && dma_read_ctrl_data_length != 32'd0) begin
          state_nxt = RD;
        end else if (wr_hs && dma_write_ctrl_data_length != 32'd0) begin
          state_nxt = WR;
        end
      end
      RD: begin
        // A slot freed by this cycle's pop can be refilled in the same cycle.
        rd_issue = (issue_left != 32'd0) && ((fifo_cnt != 2'd2) || rd_pop);
        if (rd_pop && beats_left == 32'd1) begin
          state_nxt = IDLE;
        end
      end
      WR: begin
        dma_write_chnl_ready = 1'b1;
        if (wr_beat && beats_left == 32'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prio_rd    <= 1'b1;
      addr       <= '0;
      beats_left <= '0;
      issue_left <= '0;
      fifo_wp    <= 1'b0;
      fifo_rp    <= 1'b0;
      fifo_cnt   <= 2'd0;
      oob_err    <= 1'b0;
      last_size  <= 3'd0;
    end else begin
      state <= state_nxt;
      if (rd_hs) begin
        addr       <= dma_read_ctrl_data_index[ADDR_W-1:0];
        beats_left <= dma_read_ctrl_data_length;
        issue_left <= dma_read_ctrl_data_length;
        last_size  <= dma_read_ctrl_data_size;
        prio_rd    <= 1'b0;
        if (rd_end > MEM_END) oob_err <= 1'b1;
      end else if (wr_hs) begin
        addr       <= dma_write_ctrl_data_index[ADDR_W-1:0];
        beats_left <= dma_write_ctrl_data_length;
        issue_left <= 32'd0;
        last_size  <= dma_write_ctrl_data_size;
        prio_rd    <= 1'b1;
        if (wr_end > MEM_END) oob_err <= 1'b1;
      end
      if (rd_issue) begin
        addr       <= addr + 1'b1;
        issue_left <= issue_left - 32'd1;
        fifo_wp    <= ~fifo_wp;
      end
      if (rd_pop) begin
        fifo_rp    <= ~fifo_rp;
        beats_left <= beats_left - 32'd1;
      end
      if (wr_beat) begin
        addr       <= addr + 1'b1;
        beats_left <= beats_left - 32'd1;
      end
      case ({rd_issue, rd_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef DMA64_RSP_BACKDOOR_EN
  logic              bd_pend;
  logic              bd_busy;
  logic              bd_we_q;
  logic [ADDR_W-1:0] bd_addr_q;
  logic [63:0]       bd_wdata_q;

  // Granting only when no ctrl valid is present keeps the SRAM free of DMA traffic next cycle.
  assign bd_grant = bd_req & (state == IDLE) & ~dma_read_ctrl_valid & ~dma_write_ctrl_valid & ~bd_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bd_pend    <= 1'b0;
      bd_ack     <= 1'b0;
      bd_busy    <= 1'b0;
      bd_we_q    <= 1'b0;
      bd_addr_q  <= '0;
      bd_wdata_q <= '0;
    end else begin
      bd_pend <= bd_grant;
      bd_ack  <= bd_pend;
      if (bd_grant) begin
        bd_busy    <= 1'b1;
        bd_we_q    <= bd_we;
        bd_addr_q  <= bd_addr;
        bd_wdata_q <= bd_wdata;
      end else if (bd_ack) begin
        bd_busy <= 1'b0;
      end
    end
  end

  assign mem_we    = wr_beat | (bd_pend & bd_we_q);
  assign mem_waddr = wr_beat ? addr : bd_addr_q;
  assign mem_wdata = wr_beat ? dma_write_chnl_data : bd_wdata_q;
`else
  assign bd_grant  = 1'b0;
  assign mem_we    = wr_beat;
  assign mem_waddr = addr;
  assign mem_wdata = dma_write_chnl_data;
`endif

  // SRAM array; the read lands directly in the skid FIFO, giving read-before-write ordering.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_issue) fifo_mem[fifo_wp] <= mem[addr];
`ifdef DMA64_RSP_BACKDOOR_EN
    if (bd_pend && !bd_we_q) bd_rdata <= mem[bd_addr_q];
`endif
  end

endmodule

// File: tb/tb_esp_dma64_responder.sv
// Self-checking bench for esp_dma64_responder: randomized bursts checked against a word-array memory model.
module tb_esp_dma64_responder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk;
  logic        rst;
  logic        rd_cv;
  logic        rd_cr;
  logic [31:0] rd_idx;
  logic [31:0] rd_len;
  logic [2:0]  rd_sz;
  logic        rd_dv;
  logic        rd_dr;
  logic [63:0] rd_data;
  logic        wr_cv;
  logic        wr_cr;
  logic [31:0] wr_idx;
  logic [31:0] wr_len;
  logic [2:0]  wr_sz;
  logic        wr_dv;
  logic        wr_dr;
  logic [63:0] wr_data;
  logic        busy;
  logic        oob_err;
  logic [2:0]  last_size;

  int checks   = 0;
  int failures = 0;

  logic [63:0] ref_mem [0:DEPTH-1];
  bit          model_prio_rd;
  bit          model_oob;
  logic [2:0]  model_size;

  esp_dma64_responder #(.ADDR_W(ADDR_W)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .dma_read_ctrl_valid        (rd_cv),
    .dma_read_ctrl_ready        (rd_cr),
    .dma_read_ctrl_data_index   (rd_idx),
    .dma_read_ctrl_data_length  (rd_len),
    .dma_read_ctrl_data_size    (rd_sz),
    .dma_read_chnl_valid        (rd_dv),
    .dma_read_chnl_ready        (rd_dr),
    .dma_read_chnl_data         (rd_data),
    .dma_write_ctrl_valid       (wr_cv),
    .dma_write_ctrl_ready       (wr_cr),
    .dma_write_ctrl_data_index  (wr_idx),
    .dma_write_ctrl_data_length (wr_len),
    .dma_write_ctrl_data_size   (wr_sz),
    .dma_write_chnl_valid       (wr_dv),
    .dma_write_chnl_ready       (wr_dr),
    .dma_write_chnl_data        (wr_data),
    .busy                       (busy),
    .oob_err                    (oob_err),
    .last_size                  (last_size)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] a);
    return a[ADDR_W-1:0];
  endfunction

  function automatic void model_reset();
    model_prio_rd = 1'b1;
    model_oob     = 1'b0;
    model_size    = 3'd0;
  endfunction

  // Driver: one ctrl request, issued while the responder is idle
  task automatic ctrl_hs(input bit is_rd, input logic [31:0] idx, input logic [31:0] len,
                         input logic [2:0] sz);
    logic        rdy;
    logic        other;
    logic [63:0] req_end;
    int          n;
    @(negedge clk);
    if (is_rd) begin
      rd_cv = 1'b1; rd_idx = idx; rd_len = len; rd_sz = sz;
    end else begin
      wr_cv = 1'b1; wr_idx = idx; wr_len = len; wr_sz = sz;
    end
    #1;
    rdy   = is_rd ? rd_cr : wr_cr;
    other = is_rd ? wr_cr : rd_cr;
    checks++;
    if (rdy !== 1'b1 || other !== 1'b0) begin
      failures++;
      $display("FAIL ctrl_ready_idle: ready=%b other=%b, required 1 and 0", rdy, other);
    end
    n = 0;
    while (rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      rdy = is_rd ? rd_cr : wr_cr;
      n++;
    end
    @(posedge clk);
    model_prio_rd = !is_rd;
    model_size    = sz;
    req_end       = 64'(idx) + 64'(len);
    if (req_end > 64'(DEPTH)) model_oob = 1'b1;
    #1;
    if (is_rd) rd_cv = 1'b0; else wr_cv = 1'b0;
    checks++;
    if (last_size !== model_size || oob_err !== model_oob) begin
      failures++;
      $display("FAIL ctrl_capture: last_size=%0d oob_err=%b, required %0d %b",
               last_size, oob_err, model_size, model_oob);
    end
  endtask

  task automatic write_burst(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz,
                             input bit gaps, input bit fixed, input logic [63:0] base);
    int sent;
    int budget;
    bit v;
    ctrl_hs(1'b0, idx, len, sz);
    sent   = 0;
    budget = int'(len) * 8 + 20;
    while (sent < int'(len) && budget > 0) begin
      @(negedge clk);
      v       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_dv   = v;
      wr_data = fixed ? base + 64'(sent) : {$urandom, $urandom};
      #1;
      checks++;
      if (wr_dr !== 1'b1) begin
        failures++;
        $display("FAIL wr_chnl_ready: got %b during beat %0d, required 1", wr_dr, sent);
      end
      if (v) begin
        ref_mem[word_addr(idx + 32'(sent))] = wr_data;
        sent++;
      end
      budget--;
    end
    @(negedge clk);
    wr_dv = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || wr_dr !== 1'b0) begin
      failures++;
      $display("FAIL wr_end: busy=%b wr_chnl_ready=%b, required 0 0", busy, wr_dr);
    end
  endtask

  // Scoreboard: expected beats come from the memory model; mode 0 ready high, 1 toggling, 2 random
  task automatic read_burst(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz,
                            input int mode, input bit chk_lat);
    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [63:0] held;
    int          got;
    int          lat;
    int          budget;
    bit          seen;
    bit          stalled;
    for (int i = 0; i < int'(len); i++) exp_q.push_back(ref_mem[word_addr(idx + 32'(i))]);
    ctrl_hs(1'b1, idx, len, sz);
    got = 0; lat = 0; seen = 1'b0; stalled = 1'b0; held = '0;
    budget = int'(len) * 4 + 20;
    while (got < int'(len) && budget > 0) begin
      @(negedge clk);
      case (mode)
        0:       rd_dr = 1'b1;
        1:       rd_dr = ~rd_dr;
        default: rd_dr = 1'($urandom_range(0, 1));
      endcase
      #1;
      lat++;
      budget--;
      if (stalled) begin
        checks++;
        if (rd_dv !== 1'b1 || rd_data !== held) begin
          failures++;
          $display("FAIL rd_stall_hold: valid=%b data=%h, required 1 %h", rd_dv, rd_data, held);
        end
      end
      stalled = 1'b0;
      if (rd_dv === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          if (chk_lat) begin
            checks++;
            if (lat != 2) begin
              failures++;
              $display("FAIL rd_latency: first valid %0d cycles after handshake, required 2", lat);
            end
          end
        end
        if (rd_dr) begin
          e = exp_q.pop_front();
          checks++;
          if (rd_data !== e) begin
            failures++;
            $display("FAIL rd_data: beat %0d got %h, required %h", got, rd_data, e);
          end
          got++;
        end else begin
          stalled = 1'b1;
          held    = rd_data;
        end
      end
    end
    checks++;
    if (got != int'(len)) begin
      failures++;
      $display("FAIL rd_beat_count: got %0d beats, required %0d", got, len);
    end
    @(negedge clk);
    rd_dr = 1'b0;
    #1;
    checks++;
    if (rd_dv !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_end: valid=%b busy=%b, required 0 0", rd_dv, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (rd_cr !== 1'b0 || wr_cr !== 1'b0 || rd_dv !== 1'b0 || wr_dr !== 1'b0 ||
        rd_data !== 64'd0 || busy !== 1'b0 || oob_err !== 1'b0 || last_size !== 3'd0) begin
      failures++;
      $display("FAIL %s: rcr=%b wcr=%b rv=%b wr=%b data=%h busy=%b oob=%b size=%0d, required all 0",
               tag, rd_cr, wr_cr, rd_dv, wr_dr, rd_data, busy, oob_err, last_size);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    #1;
    check_reset_outputs("reset_hold");
    rd_cv = 1'b1;
    #1;
    checks++;
    if (rd_cr !== 1'b1 || wr_cr !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl_eq: rd_ready=%b wr_ready=%b, required 1 0", rd_cr, wr_cr);
    end
    rd_cv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_release");
  endtask

  task automatic test_round_robin();
    bit exp_rd;
    @(negedge clk);
    rd_cv = 1'b1; rd_idx = 32'h40; rd_len = 32'd0; rd_sz = 3'd1;
    wr_cv = 1'b1; wr_idx = 32'h50; wr_len = 32'd0; wr_sz = 3'd6;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_rd = model_prio_rd;
      checks++;
      if (rd_cr !== exp_rd || wr_cr !== !exp_rd) begin
        failures++;
        $display("FAIL rr_grant%0d: rd_ready=%b wr_ready=%b, required %b %b",
                 k, rd_cr, wr_cr, exp_rd, !exp_rd);
      end
      @(posedge clk);
      model_prio_rd = !exp_rd;
      model_size    = exp_rd ? 3'd1 : 3'd6;
      #1;
      checks++;
      if (last_size !== model_size || busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_capture%0d: last_size=%0d busy=%b, required %0d 0",
                 k, last_size, busy, model_size);
      end
      @(negedge clk);
    end
    rd_cv = 1'b0;
    wr_cv = 1'b0;
  endtask

  task automatic test_basic();
    write_burst(32'h10, 32'd4, 3'd3, 1'b0, 1'b1, 64'hA0);
    read_burst(32'h10, 32'd4, 3'd3, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    write_burst(32'h200, 32'd8, 3'd2, 1'b1, 1'b0, 64'd0);
    rd_dr = 1'b0;
    read_burst(32'h200, 32'd8, 3'd2, 1, 1'b1);
  endtask

  task automatic test_zero_len();
    bit bad;
    ctrl_hs(1'b1, 32'h20, 32'd0, 3'd5);
    bad = 1'b0;
    rd_dr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (rd_dv !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    rd_dr = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL zero_len: chnl_valid or busy rose after length-0 request, required none");
    end
  endtask

  task automatic test_random();
    logic [31:0] idx;
    logic [31:0] len;
    for (int it = 0; it < 4; it++) begin
      idx = 32'($urandom_range(32'h300, 32'hF00));
      len = 32'($urandom_range(1, 6));
      write_burst(idx, len, 3'($urandom_range(0, 7)), 1'b1, 1'b0, 64'd0);
      read_burst(idx, len, 3'($urandom_range(0, 7)), 2, 1'b0);
    end
  endtask

  task automatic test_wrap();
    checks++;
    if (oob_err !== 1'b0) begin
      failures++;
      $display("FAIL oob_before_wrap: oob_err=%b, required 0", oob_err);
    end
    write_burst(32'(DEPTH - 2), 32'd4, 3'd4, 1'b0, 1'b0, 64'd0);
    read_burst(32'(DEPTH - 2), 32'd4, 3'd4, 0, 1'b0);
    read_burst(32'd0, 32'd2, 3'd0, 2, 1'b0);
    checks++;
    if (oob_err !== 1'b1) begin
      failures++;
      $display("FAIL oob_sticky: oob_err=%b, required 1", oob_err);
    end
  endtask

  task automatic test_reset_midburst();
    int beats;
    int budget;
    bit found;
    write_burst(32'h100, 32'd8, 3'd3, 1'b0, 1'b0, 64'd0);
    ctrl_hs(1'b1, 32'h100, 32'd8, 3'd3);
    beats = 0; budget = 40; found = 1'b0;
    while (budget > 0 && !found) begin
      @(negedge clk);
      rd_dr = 1'b1;
      #1;
      budget--;
      if (rd_dv === 1'b1) begin
        if (beats == 2) begin
          found = 1'b1;
        end else begin
          checks++;
          if (rd_data !== ref_mem[word_addr(32'h100 + 32'(beats))]) begin
            failures++;
            $display("FAIL pre_abort_data: beat %0d got %h", beats, rd_data);
          end
          beats++;
        end
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL abort_setup: beat 3 never presented, beats=%0d required 2", beats);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("midburst_reset");
    @(negedge clk);
    rst   = 1'b0;
    rd_dr = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midburst_release");
    read_burst(32'h100, 32'd8, 3'd3, 2, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    rd_cv = 1'b0; rd_idx = '0; rd_len = '0; rd_sz = '0; rd_dr = 1'b0;
    wr_cv = 1'b0; wr_idx = '0; wr_len = '0; wr_sz = '0; wr_dv = 1'b0; wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    test_reset();
    test_round_robin();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_random();
    test_wrap();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
